// File: rtl/sequential_divider.sv
// rtl/sequential_divider.sv - signed restoring divider, one quotient bit per clock
// Produces a truncating quotient and remainder for signed operands, with a divide-by-zero flag.
module sequential_divider #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder,
  output logic         done,
  output logic         busy,
  output logic         div_by_zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  localparam int CW = $clog2(W + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt;
  logic [W-1:0]  dvd_q;
  logic [W-1:0]  q_sr;
  logic [W-1:0]  rem;
  logic [W:0]    dvs_mag;
  logic [W:0]    dvd_mag_in;
  logic [W:0]    dvs_mag_in;
  logic [W:0]    shifted;
  logic          neg_q;
  logic          neg_r;
  logic          zero_q;
  logic          take;
  logic          last;

  // Magnitudes are one bit wider so that the most negative operand negates exactly.
  always_comb begin
    dvd_mag_in = dividend[W-1] ? -{dividend[W-1], dividend} : {1'b0, dividend};
    dvs_mag_in = divisor[W-1]  ? -{divisor[W-1], divisor}   : {1'b0, divisor};
    shifted    = {rem, q_sr[W-1]};
    take       = (shifted >= dvs_mag);
    last       = (cnt == CW'(W - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    done      = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        if (last) begin
          state_nxt = FIX;
        end
      end
      FIX: begin
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      dvd_q       <= '0;
      q_sr        <= '0;
      rem         <= '0;
      dvs_mag     <= '0;
      neg_q       <= 1'b0;
      neg_r       <= 1'b0;
      zero_q      <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            cnt     <= '0;
            dvd_q   <= dividend;
            q_sr    <= dvd_mag_in[W-1:0];
            // Top magnitude bit seeds the partial remainder so the full W+1-bit value is divided.
            rem     <= {{(W-1){1'b0}}, dvd_mag_in[W]};
            dvs_mag <= dvs_mag_in;
            neg_q   <= dividend[W-1] ^ divisor[W-1];
            neg_r   <= dividend[W-1];
            zero_q  <= (divisor == '0);
          end
        end
        CALC: begin
          // Remainder stays below the divisor, so the low W bits of the difference are exact.
          rem  <= take ? (shifted[W-1:0] - dvs_mag[W-1:0]) : shifted[W-1:0];
          q_sr <= {q_sr[W-2:0], take};
          cnt  <= cnt + 1'b1;
        end
        FIX: begin
          if (zero_q) begin
            quotient    <= '1;
            remainder   <= dvd_q;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= neg_q ? -q_sr : q_sr;
            remainder   <= neg_r ? -rem : rem;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sequential_divider.sv
// tb/tb_sequential_divider.sv - self-checking bench for sequential_divider
// Directed corner cases plus random signed pairs against an arithmetic reference model.
module tb_sequential_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         done;
  logic         busy;
  logic         div_by_zero;

  int n_checks;
  int n_errors;

  sequential_divider #(.W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .remainder  (remainder),
    .done       (done),
    .busy       (busy),
    .div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Launches one division and waits for done; mode 1 re-pulses start at cycle 10, mode 2 asserts rst there.
  task automatic do_div(input logic [W-1:0] a, input logic [W-1:0] b, input int mode,
                        output int lat, output bit busy_ok);
    int cyc;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    cyc     = 0;
    lat     = -1;
    busy_ok = 1'b1;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (done) begin
        lat = cyc;
        break;
      end
      if (!busy) busy_ok = 1'b0;
      if (cyc == 10 && mode == 1) begin
        dividend = 32'd999;
        divisor  = 32'd1;
        start    = 1'b1;
      end
      if (cyc == 10 && mode == 2) begin
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      @(posedge clk);
    end
  endtask

  task automatic ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r);
    longint la, lb, lq, lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    lq = la / lb;
    lr = la % lb;
    q  = lq[W-1:0];
    r  = lr[W-1:0];
  endtask

  task automatic dir_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eq, input logic [W-1:0] er, input bit edz, input int elat);
    int lat;
    bit bok;
    do_div(a, b, 0, lat, bok);
    check({tag, "_lat"}, 64'(lat), 64'(elat));
    check({tag, "_q"}, 64'(quotient), 64'(eq));
    check({tag, "_r"}, 64'(remainder), 64'(er));
    check({tag, "_dbz"}, 64'(div_by_zero), 64'(edz));
  endtask

  initial begin
    int lat;
    bit bok;
    int first_done;
    int second_done;
    logic [W-1:0] a, b, eq, er;
    logic [W-1:0] prod;

    n_checks = 0;
    n_errors = 0;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_q", 64'(quotient), 64'd0);
    check("reset_r", 64'(remainder), 64'd0);
    check("reset_busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);

    do_div(32'd150, 32'd10, 0, lat, bok);
    check("150_10_lat", 64'(lat), 64'd34);
    check("150_10_busy", 64'(bok), 64'd1);
    check("150_10_q", 64'(quotient), 64'd15);
    check("150_10_r", 64'(remainder), 64'd0);
    @(negedge clk);
    check("done_one_cycle", {62'd0, done, busy}, 64'd0);

    dir_div("m7_2", -32'sd7, 32'd2, -32'sd3, -32'sd1, 1'b0, 34);
    dir_div("7_m2", 32'd7, -32'sd2, -32'sd3, 32'd1, 1'b0, 34);
    dir_div("m8_m8", -32'sd8, -32'sd8, 32'd1, 32'd0, 1'b0, 34);
    dir_div("ovf", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0, 34);
    dir_div("max_1", 32'h7FFFFFFF, 32'd1, 32'h7FFFFFFF, 32'd0, 1'b0, 34);
    dir_div("zero_dvd", 32'd0, 32'd77, 32'd0, 32'd0, 1'b0, 34);
    dir_div("min_min", 32'h80000000, 32'h80000000, 32'd1, 32'd0, 1'b0, 34);
    dir_div("div0", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1'b1, 2);
    dir_div("after_div0", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, 34);

    do_div(32'd1234, 32'd10, 1, lat, bok);
    check("ignore_start_lat", 64'(lat), 64'd34);
    check("ignore_start_q", 64'(quotient), 64'd123);
    check("ignore_start_r", 64'(remainder), 64'd4);

    do_div(32'd500, 32'd7, 2, lat, bok);
    check("abort_q", 64'(quotient), 64'd0);
    check("abort_r", 64'(remainder), 64'd0);
    check("abort_busy_done_dbz", {61'd0, busy, done, div_by_zero}, 64'd0);
    bok = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) bok = 1'b1;
    end
    check("abort_quiet", 64'(bok), 64'd0);

    // start held high: consecutive done pulses are W+3 cycles apart
    @(negedge clk);
    dividend    = 32'd100;
    divisor     = 32'd7;
    start       = 1'b1;
    first_done  = -1;
    second_done = -1;
    for (int c = 0; c < 200 && second_done < 0; c++) begin
      @(negedge clk);
      if (done) begin
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
    end
    start = 1'b0;
    check("b2b_seen", 64'(second_done >= 0), 64'd1);
    check("b2b_period", 64'(second_done - first_done), 64'd35);
    check("b2b_q", 64'(quotient), 64'd14);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(0, 31);
      if ($urandom_range(0, 2) == 0) begin
        b = W'($urandom_range(1, 20));
        if ($urandom_range(0, 1) == 1) b = -b;
      end
      if (b == '0) b = 32'd3;
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) b = 32'd2;
      ref_div(a, b, eq, er);
      do_div(a, b, 0, lat, bok);
      check("rnd_lat", 64'(lat), 64'd34);
      check("rnd_q", 64'(quotient), 64'(eq));
      check("rnd_r", 64'(remainder), 64'(er));
      prod = quotient * b + remainder;
      check("rnd_identity", 64'(prod), 64'(a));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 Parameter: W, 32, operand and result width in bits.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst  input  1  reset, synchronous, active-high.
REQ-004 Port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 Port: dividend  input  W  signed two's-complement dividend.
REQ-006 Port: divisor  input  W  signed two's-complement divisor.
REQ-007 Port: quotient  output  W  signed quotient, registered.
REQ-008 Port: remainder  output  W  signed remainder, registered.
REQ-009 Port: done  output  1  one-cycle pulse; quotient, remainder and div_by_zero are valid.
REQ-010 Port: busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 Port: div_by_zero  output  1  registered flag; high when the last completed division had divisor 0.

Function
REQ-012 The FSM SHALL have the states IDLE, CALC, FIX and DONE.
REQ-013 IDLE with start=1 SHALL capture dividend and divisor in that cycle (cycle N) and go to CALC, or to FIX if divisor==0.
REQ-014 start SHALL be ignored in CALC, FIX and DONE; operands SHALL NOT be re-sampled while busy=1.
REQ-015 CALC SHALL run an unsigned restoring shift-subtract on |dividend| and |divisor|, one quotient bit per cycle, for exactly W cycles (N+1..N+W).
REQ-016 Magnitudes SHALL use a W+1-bit internal width so that |-2^(W-1)| is represented exactly.
REQ-017 FIX (cycle N+W+1) SHALL apply signs and write quotient, remainder and div_by_zero.
REQ-018 Quotient sign SHALL be dividend_sign XOR divisor_sign; remainder sign SHALL follow the dividend (truncation toward zero, same as Verilog / and %).
REQ-019 The identity dividend == quotient*divisor + remainder SHALL hold, with |remainder| < |divisor|.
REQ-020 done SHALL be high only in DONE (cycle N+W+2, latency W+2), for exactly one cycle; DONE SHALL then go to IDLE.
REQ-021 quotient, remainder and div_by_zero SHALL hold their values from FIX until the next FIX or reset.
REQ-022 divisor==0: path IDLE->FIX->DONE, done at cycle N+2; quotient = all ones, remainder = dividend, div_by_zero = 1.
REQ-023 Any divide with divisor!=0 SHALL clear div_by_zero at its FIX.
REQ-024 Overflow (-2^(W-1) / -1) SHALL give quotient = -2^(W-1) (wrapped), remainder = 0, div_by_zero = 0; no separate flag.
REQ-025 A zero dividend SHALL give quotient 0 and remainder 0 after the full latency.
REQ-026 start=1 held continuously SHALL begin a new division in the first IDLE cycle after DONE (back-to-back period W+3).

Reset
REQ-027 rst=1 at a clock edge SHALL force IDLE, with quotient=0, remainder=0, done=0, busy=0 and div_by_zero=0.
REQ-028 Reset SHALL take priority over start in the same cycle.
REQ-029 Reset mid-operation (CALC, FIX or DONE) SHALL abort with no done pulse and clear the internal partial results.

Verification
REQ-030 The bench SHALL cover these directed scenarios (W=32):
- 150 / 10 -> quotient 15, remainder 0, done exactly 34 cycles after the start cycle, busy high in cycles 1..34.
- -7 / 2 -> quotient -3, remainder -1; 7 / -2 -> quotient -3, remainder 1; -8 / -8 -> quotient 1, remainder 0.
- 32'h80000000 / 32'hFFFFFFFF -> quotient 32'h80000000, remainder 0, div_by_zero 0; 32'h7FFFFFFF / 1 -> quotient 32'h7FFFFFFF, remainder 0.
- 5 / 0 -> done at cycle N+2, quotient 32'hFFFFFFFF, remainder 5, div_by_zero 1; a following 9 / 3 -> quotient 3, div_by_zero 0.
- start pulsed again in cycle N+10 with different operands -> ignored, result still from the first operands; rst in cycle N+10 -> no done, all outputs 0, busy 0 next cycle.
- 1000 random signed pairs (divisor != 0) checked against Verilog / and %, and a multiplier check of quotient*divisor + remainder == dividend.
